// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port (WE3/AD3/WD3) between
// core writeback (port A, always wins) and a buffered secondary requester (port B).
// Port-B writes wait in a small FIFO and drain in cycles where A is idle; a
// starvation guard stalls the core once the FIFO head has waited too long.
// Optional feature macro: REGFILE_ARB_FWD_EN adds q_fwd_vld/q_fwd_data, which
// forward the data of the newest queued write to q_addr.
module regfile_wb_arbiter #(
   parameter int unsigned D_WIDTH  = 32,
   parameter int unsigned A_WIDTH  = 5,
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned MAX_WAIT = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               a_we,
   input  logic [A_WIDTH-1:0] a_addr,
   input  logic [D_WIDTH-1:0] a_data,
   input  logic               b_valid,
   output logic               b_ready,
   input  logic [A_WIDTH-1:0] b_addr,
   input  logic [D_WIDTH-1:0] b_data,
   input  logic [A_WIDTH-1:0] q_addr,
   output logic               q_pend,
   output logic               stall,
   output logic               err,
   output logic               rf_we,
   output logic [A_WIDTH-1:0] rf_addr,
   output logic [D_WIDTH-1:0] rf_data
`ifdef REGFILE_ARB_FWD_EN
   ,
   output logic               q_fwd_vld,
   output logic [D_WIDTH-1:0] q_fwd_data
`endif
);

   localparam int unsigned PTR_W  = $clog2(DEPTH);
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam int unsigned WAIT_W = $clog2(MAX_WAIT) + 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_PEND   = 2'd1,
      ST_STARVE = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [WAIT_W-1:0]  wait_q, wait_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
   logic [DEPTH-1:0]   vld_q;
   logic [A_WIDTH-1:0] addr_q [DEPTH];
   logic [D_WIDTH-1:0] data_q [DEPTH];
   logic               stall_q, stall_d;
   logic               err_q, err_d;
   logic               b_ready_q, b_ready_d;
   logic               rf_we_q, rf_we_d;
   logic [A_WIDTH-1:0] rf_addr_q, rf_addr_d;
   logic [D_WIDTH-1:0] rf_data_q, rf_data_d;

   logic               a_wr_c;
   logic               push_c;
   logic               pop_c;
   logic               blocked_c;
   logic [WAIT_W-1:0]  wait_inc_c;

   // Request decode: any a_we consumes the slot, even the x0 no-op.
   always_comb begin
      a_wr_c     = a_we && (a_addr != '0);
      push_c     = b_valid && b_ready_q && (b_addr != '0);
      pop_c      = !a_we && (count_q != '0);
      blocked_c  = a_we && (count_q != '0);
      count_d    = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
      b_ready_d  = (count_d < CNT_W'(DEPTH));
      wait_inc_c = (wait_q == WAIT_W'(MAX_WAIT)) ? wait_q : wait_q + WAIT_W'(1);
   end

   // Next-state logic for the starvation guard and sticky protocol error.
   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      err_d   = err_q | (a_we & stall_q);
      unique case (state_q)
         ST_IDLE: begin
            wait_d = '0;
            if (push_c) state_d = ST_PEND;
         end
         ST_PEND: begin
            if (pop_c) begin
               wait_d = '0;
               if ((count_q == CNT_W'(1)) && !push_c) state_d = ST_IDLE;
            end else if (blocked_c) begin
               wait_d = wait_inc_c;
               if (wait_q == WAIT_W'(MAX_WAIT - 1)) state_d = ST_STARVE;
            end
         end
         ST_STARVE: begin
            if (pop_c) begin
               wait_d  = '0;
               state_d = ((count_q == CNT_W'(1)) && !push_c) ? ST_IDLE : ST_PEND;
            end else if (blocked_c) begin
               wait_d = wait_inc_c;
            end
         end
         default: begin
            state_d = ST_IDLE;
            wait_d  = '0;
         end
      endcase
      stall_d = (state_d == ST_STARVE);
   end

   // Write-port selection: A first, then the FIFO head; address holds when idle.
   always_comb begin
      rf_we_d   = 1'b0;
      rf_addr_d = rf_addr_q;
      rf_data_d = rf_data_q;
      if (a_wr_c) begin
         rf_we_d   = 1'b1;
         rf_addr_d = a_addr;
         rf_data_d = a_data;
      end else if (pop_c) begin
         rf_we_d   = 1'b1;
         rf_addr_d = addr_q[rd_ptr_q];
         rf_data_d = data_q[rd_ptr_q];
      end
   end

   // Control and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         wait_q    <= '0;
         count_q   <= '0;
         stall_q   <= 1'b0;
         err_q     <= 1'b0;
         b_ready_q <= 1'b1;
         rf_we_q   <= 1'b0;
         rf_addr_q <= '0;
         rf_data_q <= '0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         count_q   <= count_d;
         stall_q   <= stall_d;
         err_q     <= err_d;
         b_ready_q <= b_ready_d;
         rf_we_q   <= rf_we_d;
         rf_addr_q <= rf_addr_d;
         rf_data_q <= rf_data_d;
      end
   end

   // Port-B FIFO storage with per-entry valid bits for the hazard query.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         vld_q    <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else begin
         if (pop_c) begin
            vld_q[rd_ptr_q] <= 1'b0;
            rd_ptr_q        <= rd_ptr_q + PTR_W'(1);
         end
         if (push_c) begin
            vld_q[wr_ptr_q]  <= 1'b1;
            addr_q[wr_ptr_q] <= b_addr;
            data_q[wr_ptr_q] <= b_data;
            wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
         end
      end
   end

   // Hazard query: any queued write to q_addr; x0 never hazards.
   always_comb begin
      q_pend = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (vld_q[i] && (addr_q[i] == q_addr)) q_pend = 1'b1;
      end
      if (q_addr == '0) q_pend = 1'b0;
   end

`ifdef REGFILE_ARB_FWD_EN
   logic [PTR_W-1:0] fwd_idx;

   // Forwarding: walk oldest to newest so the newest match wins.
   always_comb begin
      fwd_idx    = '0;
      q_fwd_data = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         fwd_idx = rd_ptr_q + PTR_W'(i);
         if (vld_q[fwd_idx] && (addr_q[fwd_idx] == q_addr)) q_fwd_data = data_q[fwd_idx];
      end
      q_fwd_vld = q_pend;
   end
`endif

   assign b_ready = b_ready_q;
   assign stall   = stall_q;
   assign err     = err_q;
   assign rf_we   = rf_we_q;
   assign rf_addr = rf_addr_q;
   assign rf_data = rf_data_q;

endmodule
